// File: rtl/video_pkg.sv
// Shared constants for the text-mode video compositor:
// cursor styles, pin levels and default geometry.
package video_pkg;

   localparam logic [1:0] CUR_OFF       = 2'b00;
   localparam logic [1:0] CUR_BLOCK     = 2'b01;
   localparam logic [1:0] CUR_UNDERLINE = 2'b10;

   localparam logic VIDEO_ON  = 1'b1;
   localparam logic video_off = ~VIDEO_ON;

   localparam int COLS   = 64;
   localparam int ROWS   = 16;
   localparam int CHAR_H = 16;

endpackage

// File: rtl/cursor_blinker_ctl.sv
// Frame-tick detector and blink phase generator for the cursor.
// A cursor write restarts the blink period with the cursor visible.
module cursor_blinker_ctl #(
   parameter int BLINK_FRAMES = 16
) (
   input  logic clk,
   input  logic clr,
   input  logic vblank,
   input  logic restart,
   output logic blink_on
);

   localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CW-1:0] LAST = CW'(BLINK_FRAMES - 1);

   logic          vblank_d;
   logic [CW-1:0] count;
   logic          tick;

   assign tick = vblank & ~vblank_d;

   always_ff @(posedge clk) begin
      if (!clr) begin
         vblank_d <= 1'b0;
         count    <= '0;
         blink_on <= 1'b1;
      end else begin
         vblank_d <= vblank;
         if (restart) begin
            count    <= '0;
            blink_on <= 1'b1;
         end else if (tick) begin
            if (count == LAST) begin
               count    <= '0;
               blink_on <= ~blink_on;
            end else begin
               count <= count + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/video_compositor.sv
// Pixel compositor: cursor overlay, blink, reverse video and blanking,
// with hsync/vsync delayed to match the single output register.
module video_compositor #(
   parameter int   COL_BITS     = 6,
   parameter int   ROW_BITS     = 4,
   parameter int   COLS         = video_pkg::COLS,
   parameter int   ROWS         = video_pkg::ROWS,
   parameter int   CHAR_H       = video_pkg::CHAR_H,
   parameter int   UL_LINES     = 2,
   parameter int   BLINK_FRAMES = 16,
   parameter logic VIDEO_ON     = video_pkg::VIDEO_ON
) (
   input  logic                      clk,
   input  logic                      clr,
   input  logic                      px_en,
   input  logic                      hblank,
   input  logic                      vblank,
   input  logic                      hsync_in,
   input  logic                      vsync_in,
   input  logic                      char_pixel,
   input  logic [COL_BITS-1:0]       col,
   input  logic [ROW_BITS-1:0]       row,
   input  logic [$clog2(CHAR_H)-1:0] scanline,
   input  logic [COL_BITS-1:0]       new_cursor_x,
   input  logic [ROW_BITS-1:0]       new_cursor_y,
   input  logic                      new_cursor_wen,
   input  logic [1:0]                cursor_style,
   input  logic                      blink_en,
   input  logic                      reverse,
   output logic                      video,
   output logic                      hsync,
   output logic                      vsync,
   output logic [COL_BITS-1:0]       cursor_x,
   output logic [ROW_BITS-1:0]       cursor_y,
   output logic                      blink_on
);

   import video_pkg::*;

   localparam int SL_W = $clog2(CHAR_H);
   localparam logic [COL_BITS-1:0] X_MAX = COL_BITS'(COLS - 1);
   localparam logic [ROW_BITS-1:0] Y_MAX = ROW_BITS'(ROWS - 1);
   localparam logic [SL_W-1:0] UL_TOP = SL_W'(CHAR_H - UL_LINES);
   localparam logic PIX_OFF = ~VIDEO_ON;

   logic under;
   logic visible;
   logic mask;
   logic pixel;

   cursor_blinker_ctl #(
      .BLINK_FRAMES(BLINK_FRAMES)
   ) u_blink (
      .clk      (clk),
      .clr      (clr),
      .vblank   (vblank),
      .restart  (new_cursor_wen),
      .blink_on (blink_on)
   );

   always_ff @(posedge clk) begin
      if (!clr) begin
         cursor_x <= '0;
         cursor_y <= '0;
      end else if (new_cursor_wen) begin
         cursor_x <= (new_cursor_x > X_MAX) ? X_MAX : new_cursor_x;
         cursor_y <= (new_cursor_y > Y_MAX) ? Y_MAX : new_cursor_y;
      end
   end

   always_comb begin
      mask = 1'b0;
      case (cursor_style)
         CUR_OFF:       mask = 1'b0;
         CUR_UNDERLINE: mask = (scanline >= UL_TOP);
         default:       mask = 1'b1;
      endcase
   end

   assign under   = (col == cursor_x) & (row == cursor_y);
   assign visible = blink_en ? blink_on : 1'b1;
   assign pixel   = char_pixel ^ reverse ^ (under & visible & mask);

   always_ff @(posedge clk) begin
      if (!clr) begin
         video <= PIX_OFF;
         hsync <= 1'b0;
         vsync <= 1'b0;
      end else if (px_en) begin
         // blanking overrides reverse video
         video <= (hblank | vblank) ? PIX_OFF
                : (pixel ? VIDEO_ON : PIX_OFF);
         hsync <= hsync_in;
         vsync <= vsync_in;
      end
   end

endmodule

// File: tb/tb_video_compositor.sv
// Randomized and directed checks of video_compositor against a
// frame-level behavioural model.
module tb_video_compositor;

   localparam int NCOLS = 60;
   localparam int NROWS = 12;
   localparam int BF    = 16;

   logic       clk = 0;
   logic       clr, px_en, hblank, vblank, hsync_in, vsync_in;
   logic       char_pixel, new_cursor_wen, blink_en, reverse;
   logic [5:0] col, new_cursor_x;
   logic [3:0] row, new_cursor_y, scanline;
   logic [1:0] cursor_style;
   logic       video, hsync, vsync, blink_on;
   logic [5:0] cursor_x;
   logic [3:0] cursor_y;

   int n_checks = 0;
   int n_errors = 0;

   // model state
   bit m_video, m_hs, m_vs, m_blink, m_vbd;
   int m_cx, m_cy, m_frames;

   always #5 clk = ~clk;

   video_compositor #(
      .COLS(NCOLS), .ROWS(NROWS), .BLINK_FRAMES(BF)
   ) dut (
      .clk(clk), .clr(clr), .px_en(px_en),
      .hblank(hblank), .vblank(vblank),
      .hsync_in(hsync_in), .vsync_in(vsync_in),
      .char_pixel(char_pixel), .col(col), .row(row),
      .scanline(scanline),
      .new_cursor_x(new_cursor_x), .new_cursor_y(new_cursor_y),
      .new_cursor_wen(new_cursor_wen),
      .cursor_style(cursor_style), .blink_en(blink_en),
      .reverse(reverse), .video(video),
      .hsync(hsync), .vsync(vsync),
      .cursor_x(cursor_x), .cursor_y(cursor_y),
      .blink_on(blink_on)
   );

   task automatic check(string tag, int got, int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  tag, got, exp, $time);
      end
   endtask

   // advance one clock, update the model from the inputs seen at
   // the edge, then compare every output
   task automatic step();
      bit vis, und, msk, pix, tick;
      @(posedge clk);
      if (!clr) begin
         m_video = 0; m_hs = 0; m_vs = 0;
         m_cx = 0; m_cy = 0;
         m_blink = 1; m_frames = 0; m_vbd = 0;
      end else begin
         vis = blink_en ? m_blink : 1'b1;
         und = (int'(col) == m_cx) && (int'(row) == m_cy);
         if (cursor_style == 2'b00) msk = 0;
         else if (cursor_style == 2'b10) msk = (scanline >= 14);
         else msk = 1;
         pix = char_pixel ^ reverse ^ (und & vis & msk);
         if (px_en) begin
            m_video = (hblank || vblank) ? 1'b0 : pix;
            m_hs = hsync_in;
            m_vs = vsync_in;
         end
         tick = vblank && !m_vbd;
         m_vbd = vblank;
         if (new_cursor_wen) begin
            m_cx = (new_cursor_x > NCOLS - 1) ? NCOLS - 1 : new_cursor_x;
            m_cy = (new_cursor_y > NROWS - 1) ? NROWS - 1 : new_cursor_y;
            m_frames = 0;
            m_blink = 1;
         end else if (tick) begin
            m_frames++;
            if (m_frames == BF) begin
               m_frames = 0;
               m_blink = !m_blink;
            end
         end
      end
      #1;
      check("video", video, m_video);
      check("hsync", hsync, m_hs);
      check("vsync", vsync, m_vs);
      check("cursor_x", cursor_x, m_cx);
      check("cursor_y", cursor_y, m_cy);
      check("blink_on", blink_on, m_blink);
   endtask

   task automatic idle_inputs();
      px_en = 1; hblank = 0; vblank = 0;
      hsync_in = 0; vsync_in = 0; char_pixel = 0;
      col = 0; row = 0; scanline = 0;
      new_cursor_x = 0; new_cursor_y = 0; new_cursor_wen = 0;
      cursor_style = 0; blink_en = 0; reverse = 0;
   endtask

   task automatic frame(bit wr);
      vblank = 1; new_cursor_wen = wr;
      step();
      new_cursor_wen = 0;
      step();
      vblank = 0;
      step();
      step();
   endtask

   initial begin
      idle_inputs();
      clr = 0;
      step(); step();
      check("rst_video", video, 0);
      check("rst_blink", blink_on, 1);
      clr = 1;

      // basic pass-through with one strobe latency
      char_pixel = 1; hsync_in = 1; col = 9;
      step();
      check("first_video", video, 1);
      check("first_hsync", hsync, 1);

      // clamped cursor write
      new_cursor_x = 63; new_cursor_y = 15; new_cursor_wen = 1;
      step();
      new_cursor_wen = 0;
      check("clamp_x", cursor_x, NCOLS - 1);
      check("clamp_y", cursor_y, NROWS - 1);

      // underline and block sweeps under the cursor
      new_cursor_x = 5; new_cursor_y = 3; new_cursor_wen = 1;
      step();
      new_cursor_wen = 0;
      col = 5; row = 3; char_pixel = 0; hsync_in = 0;
      for (int st = 1; st <= 2; st++) begin
         cursor_style = (st == 1) ? 2'b10 : 2'b01;
         for (int s = 0; s < 16; s++) begin
            scanline = s[3:0];
            step();
         end
      end

      // reverse video, then blanked
      cursor_style = 2'b00; reverse = 1; col = 6;
      step();
      check("reverse_lit", video, 1);
      hblank = 1;
      step();
      check("reverse_blank", video, 0);
      hblank = 0; reverse = 0;

      // blink period and restart on a coincident tick
      blink_en = 1; cursor_style = 2'b01; col = 5;
      for (int f = 1; f <= 47; f++) begin
         frame(f == 31);
         if (f == 15) check("blink_f15", blink_on, 1);
         if (f == 16) check("blink_f16", blink_on, 0);
         if (f == 31) check("blink_restart", blink_on, 1);
         if (f == 46) check("blink_f46", blink_on, 1);
         if (f == 47) check("blink_f47", blink_on, 0);
      end

      // px_en low holds outputs
      for (int i = 0; i < 5; i++) begin
         px_en = 0;
         hsync_in = $urandom_range(0, 1);
         vsync_in = $urandom_range(0, 1);
         char_pixel = $urandom_range(0, 1);
         step();
      end
      px_en = 1;

      // mid-line reset
      hsync_in = 1; char_pixel = 1;
      step();
      clr = 0;
      step();
      check("midrst_video", video, 0);
      check("midrst_hsync", hsync, 0);
      check("midrst_cx", cursor_x, 0);
      clr = 1;

      // randomized traffic
      for (int i = 0; i < 8000; i++) begin
         clr = ($urandom_range(0, 499) != 0);
         px_en = ($urandom_range(0, 3) != 0);
         hblank = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 9) == 0) vblank = ~vblank;
         hsync_in = $urandom_range(0, 1);
         vsync_in = $urandom_range(0, 1);
         char_pixel = $urandom_range(0, 1);
         col = ($urandom_range(0, 1) != 0) ? 6'(m_cx) : 6'($urandom);
         row = ($urandom_range(0, 1) != 0) ? 4'(m_cy) : 4'($urandom);
         scanline = 4'($urandom);
         new_cursor_x = 6'($urandom);
         new_cursor_y = 4'($urandom);
         new_cursor_wen = ($urandom_range(0, 399) == 0);
         cursor_style = 2'($urandom);
         blink_en = ($urandom_range(0, 3) != 0);
         reverse = ($urandom_range(0, 3) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
